// File: rtl/uart_frame_ctrl.sv
// UART frame assembler: collects an 8-byte header/payload/checksum frame,
// verifies the checksum and holds the frame until downstream accepts it.
module uart_frame_ctrl #(
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_perr,
  output logic [63:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic        ovr_pulse,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_HOLD
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_PARITY   = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_CHECKSUM = 2'd3
  } err_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] gap_q, gap_d;
  logic [63:0] frame_q, frame_d;
  logic        fv_q, fv_d;
  logic        err_pulse_q, err_pulse_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        ovr_q, ovr_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [7:0]  payload_sum;
  logic        err_evt;

  // Checksum covers payload bytes 1..6; byte 7 carries the expected sum.
  always_comb begin
    payload_sum = frame_q[15:8] + frame_q[23:16] + frame_q[31:24]
                + frame_q[39:32] + frame_q[47:40] + frame_q[55:48];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    frame_d     = frame_q;
    fv_d        = fv_q;
    err_evt     = 1'b0;
    err_code_d  = err_code_q;
    ovr_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && !rx_perr && (rx_data == HDR_BYTE)) begin
          frame_d[7:0] = rx_data;
          idx_d        = 3'd1;
          gap_d        = '0;
          state_d      = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (rx_valid) begin
          gap_d = '0;
          if (rx_perr) begin
            err_evt    = 1'b1;
            err_code_d = ERR_PARITY;
            idx_d      = '0;
            state_d    = S_IDLE;
          end else begin
            frame_d[{idx_q, 3'b000} +: 8] = rx_data;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = S_CHECK;
          end
        end else if (gap_q == TIMEOUT_CYC) begin
          // A byte landing on the boundary cycle wins over the timeout.
          err_evt    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          idx_d      = '0;
          gap_d      = '0;
          state_d    = S_IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end

      S_CHECK: begin
        idx_d = '0;
        if (payload_sum == frame_q[63:56]) begin
          fv_d    = 1'b1;
          state_d = S_HOLD;
        end else begin
          err_evt    = 1'b1;
          err_code_d = ERR_CHECKSUM;
          state_d    = S_IDLE;
        end
      end

      S_HOLD: begin
        // Bytes are dropped here even on the handshake cycle.
        ovr_d = rx_valid;
        if (fv_q && frame_ready) begin
          fv_d        = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    err_pulse_d = err_evt;
    err_cnt_d   = (err_evt && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  // NOTE: the frame buffer is reset too, since frame_data must read zero
  // in reset and a stale partial frame must not survive it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      frame_q     <= '0;
      fv_q        <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      ovr_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      frame_q     <= frame_d;
      fv_q        <= fv_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      ovr_q       <= ovr_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_data  = frame_q;
  assign frame_valid = fv_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;
  assign ovr_pulse   = ovr_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: good/bad frames, gap timeout boundary,
// overrun in HOLD, parity errors, error-count saturation and mid-frame reset.
module tb_uart_frame_ctrl;

  localparam logic [15:0] T = 16'd20;

  localparam logic [63:0] F1     = 64'h15060504030201A5;
  localparam logic [63:0] F1_BAD = 64'h16060504030201A5;
  localparam logic [63:0] F2     = 64'h50605040302010A5;
  localparam logic [63:0] F3     = 64'hAA03020100FFA5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_perr;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic        ovr_pulse;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  uart_frame_ctrl #(.HDR_BYTE(8'hA5), .TIMEOUT_CYC(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_perr     (rx_perr),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .ovr_pulse   (ovr_pulse),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled on the following rising edge
  // and the task returns at the falling edge after it.
  task automatic send_byte(input logic [7:0] d, input logic perr);
    rx_data  = d;
    rx_perr  = perr;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_perr  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) send_byte(f[i*8 +: 8], 1'b0);
  endtask

  initial begin
    int hit;
    int ovr_seen;

    rst_n = 1'b0;
    rx_data = '0;
    rx_valid = 1'b0;
    rx_perr = 1'b0;
    frame_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_fv",    frame_valid, 0);
    check("rst_data",  frame_data,  0);
    check("rst_code",  err_code,    0);
    check("rst_ecnt",  err_cnt,     0);
    check("rst_fcnt",  frame_cnt,   0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame, 2-cycle latency, handshake with frame_ready already high.
    send_frame(F1);
    check("good_lat1", frame_valid, 0);
    @(negedge clk);
    check("good_fv",   frame_valid, 1);
    check("good_data", frame_data,  F1);
    check("good_cnt0", frame_cnt,   0);
    @(negedge clk);
    check("good_fv0",  frame_valid, 0);
    check("good_cnt1", frame_cnt,   1);

    // Checksum mismatch.
    send_frame(F1_BAD);
    @(negedge clk);
    check("cks_pulse", err_pulse,   1);
    check("cks_fv",    frame_valid, 0);
    check("cks_code",  err_code,    3);
    @(negedge clk);
    check("cks_pulse0", err_pulse,  0);
    check("cks_ecnt",  err_cnt,     1);
    check("cks_fv0",   frame_valid, 0);

    // Byte arriving on the exact timeout cycle is accepted.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    repeat (T) @(negedge clk);
    for (int i = 2; i < 8; i++) send_byte(F2[i*8 +: 8], 1'b0);
    @(negedge clk);
    check("bnd_ecnt",  err_cnt,     1);
    check("bnd_fv",    frame_valid, 1);
    check("bnd_data",  frame_data,  F2);
    @(negedge clk);
    check("bnd_cnt",   frame_cnt,   2);

    // Timeout fires on the first idle cycle after the timer reaches T.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    hit = -1;
    for (int i = 1; i <= T + 5; i++) begin
      @(negedge clk);
      if (err_pulse && hit < 0) hit = i;
    end
    check("to_cycle",  hit,         T + 1);
    check("to_code",   err_code,    2);
    check("to_ecnt",   err_cnt,     2);
    send_frame(F3);
    @(negedge clk);
    check("to_nxt_fv", frame_valid, 1);
    check("to_nxt_dat", frame_data, F3);
    @(negedge clk);
    check("to_nxt_cnt", frame_cnt,  3);

    // Overrun while held, then a header on the handshake cycle.
    frame_ready = 1'b0;
    send_frame(F1);
    @(negedge clk);
    check("ovr_fv",    frame_valid, 1);
    ovr_seen = 0;
    send_byte(8'h33, 1'b0);
    if (ovr_pulse) ovr_seen++;
    send_byte(8'hA5, 1'b0);
    if (ovr_pulse) ovr_seen++;
    send_byte(8'h44, 1'b0);
    if (ovr_pulse) ovr_seen++;
    check("ovr_count", ovr_seen,    3);
    check("ovr_data",  frame_data,  F1);
    check("ovr_fv1",   frame_valid, 1);
    check("ovr_ecnt",  err_cnt,     2);
    check("ovr_fcnt",  frame_cnt,   3);
    frame_ready = 1'b1;
    send_byte(8'hA5, 1'b0);
    check("hs_ovr",    ovr_pulse,   1);
    check("hs_fv0",    frame_valid, 0);
    check("hs_cnt",    frame_cnt,   4);
    @(negedge clk);
    check("hs_ovr0",   ovr_pulse,   0);
    send_frame(F2);
    @(negedge clk);
    check("hs_nxt_fv", frame_valid, 1);
    check("hs_nxt_dat", frame_data, F2);
    @(negedge clk);
    check("hs_nxt_cnt", frame_cnt,  5);

    // Parity: silent in IDLE, error in COLLECT.
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("par_idle",  err_cnt,     2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    check("par_pulse", err_pulse,   1);
    check("par_code",  err_code,    1);
    check("par_ecnt",  err_cnt,     3);
    @(negedge clk);
    check("par_pulse0", err_pulse,  0);

    // 300 further error events saturate the counter.
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b1);
    end
    @(negedge clk);
    check("sat_ecnt",  err_cnt,     255);
    check("sat_code",  err_code,    1);

    // Asynchronous reset after the 4th byte of a frame.
    for (int i = 0; i < 4; i++) send_byte(F1[i*8 +: 8], 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_data", frame_data,  0);
    check("mrst_fv",   frame_valid, 0);
    check("mrst_ecnt", err_cnt,     0);
    check("mrst_fcnt", frame_cnt,   0);
    check("mrst_code", err_code,    0);
    check("mrst_epls", err_pulse,   0);
    check("mrst_ovr",  ovr_pulse,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_rel",  {err_pulse, ovr_pulse, frame_valid}, 0);
    send_frame(F1);
    @(negedge clk);
    check("mrst_nfv",  frame_valid, 1);
    check("mrst_ndat", frame_data,  F1);
    @(negedge clk);
    check("mrst_ncnt", frame_cnt,   1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
